// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spart_pkg
// Purpose  : Shared types and constants for the SPART transmit arbiter:
//            transmit FSM state encoding, SPART register addresses and the
//            default acknowledge timeout.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package spart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [1:0] SPART_ADDR_TX     = 2'b00;
  localparam logic [1:0] SPART_ADDR_STATUS = 2'b01;
  localparam logic [1:0] SPART_ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] SPART_ADDR_DB_HI  = 2'b11;

  localparam int DEFAULT_ACK_TIMEOUT = 8;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter with grant lock. While locked
//            only the owner may be granted; otherwise a lone requester wins
//            and simultaneous requests are resolved by the rr pointer.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            en_i            - arbitration allowed this cycle
//            req_i[1:0]      - request vector
//            lock_i, owner_i - grant held for owner_i
//            adv_i           - move pointer away from adv_from_i
//            gnt_o[1:0]      - one-hot grant (zero when nothing accepted)
//            gnt_id_o        - index selected by the arbitration rule
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  logic       owner_i,
  input  logic       adv_i,
  input  logic       adv_from_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q;
  logic ptr_d;
  logic w_id;

  always_comb begin
    w_id = ptr_q;
    if (lock_i) begin
      w_id = owner_i;
    end else if (req_i == 2'b01) begin
      w_id = 1'b0;
    end else if (req_i == 2'b10) begin
      w_id = 1'b1;
    end
    gnt_o = 2'b00;
    if (en_i && req_i[w_id]) begin
      gnt_o[w_id] = 1'b1;
    end
    gnt_id_o = w_id;
    // Pointer always favours the requester that did not just finish.
    ptr_d = adv_i ? ~adv_from_i : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/spart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spart_tx_arbiter
// Purpose  : Shares the SPART transmitter between two byte-stream requesters.
//            Grants round-robin, holds the grant for a whole packet, issues
//            the transmit-buffer write strobe and follows tbr until the byte
//            has left the shifter. A missing tbr acknowledge raises err.
// Ports    : clk, rst                      - clock, sync active-high reset
//            reqN_valid/data/last/ready    - requester byte streams
//            tbr                           - SPART transmit buffer ready
//            iocs/iorw/ioaddr/databus      - SPART bus write cycle
//            grant_id, locked              - arbitration status
//            err, err_clr                  - sticky ack-timeout flag
//            bytes_sent                    - completed byte count (wraps)
// Revision : 1.0  initial release
// ============================================================================
module spart_tx_arbiter
  import spart_pkg::*;
#(
  parameter int         ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter logic [1:0] TX_ADDR     = SPART_ADDR_TX,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  input  logic             tbr,
  output logic             iocs,
  output logic             iorw,
  output logic [1:0]       ioaddr,
  output logic [7:0]       databus,
  output logic             grant_id,
  output logic             locked,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  tx_state_e        state_q;
  logic             iocs_q;
  logic             iorw_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic             grant_q;
  logic             locked_q;
  logic             err_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [CNT_W-1:0] bytes_q;

  logic [1:0] w_gnt;
  logic       w_gnt_id;
  logic       w_en;
  logic       w_timeout;
  logic       w_done;
  logic       w_adv;
  logic [7:0] w_data;
  logic       w_last;

  // Accepting only while tbr=1 guarantees the strobe never hits a full buffer.
  assign w_en      = (state_q == ST_IDLE) && tbr && !rst;
  assign w_timeout = (state_q == ST_WAIT_ACK) && tbr &&
                     (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
  assign w_done    = (state_q == ST_WAIT_DONE) && tbr;
  assign w_adv     = w_timeout || (w_done && last_q);
  assign w_data    = w_gnt_id ? req1_data : req0_data;
  assign w_last    = w_gnt_id ? req1_last : req0_last;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (w_en),
    .req_i      ({req1_valid, req0_valid}),
    .lock_i     (locked_q),
    .owner_i    (grant_q),
    .adv_i      (w_adv),
    .adv_from_i (grant_q),
    .gnt_o      (w_gnt),
    .gnt_id_o   (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      grant_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      bytes_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|w_gnt) begin
            data_q   <= w_data;
            last_q   <= w_last;
            grant_q  <= w_gnt_id;
            locked_q <= 1'b1;
            iocs_q   <= 1'b1;
            iorw_q   <= 1'b0;
            state_q  <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          iocs_q   <= 1'b0;
          iorw_q   <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!tbr) begin
            state_q <= ST_WAIT_DONE;
          end else if (w_timeout) begin
            // Byte is abandoned and the packet lock released.
            locked_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tbr) begin
            bytes_q <= bytes_q + CNT_W'(1);
            if (last_q) begin
              locked_q <= 1'b0;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A timeout in the same cycle as err_clr keeps the flag set.
      if (w_timeout) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = TX_ADDR;
  assign databus    = data_q;
  assign grant_id   = grant_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign bytes_sent = bytes_q;

endmodule : spart_tx_arbiter
`default_nettype wire

// File: tb/tb_spart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_tx_arbiter
// Purpose  : Self-checking bench for spart_tx_arbiter with a transaction
//            model of the arbiter, a simple SPART transmitter model and
//            queue-driven requesters (directed scenarios, then random).
// Revision : 1.0  initial release
// ============================================================================
module tb_spart_tx_arbiter;

  localparam int AT = 8;
  localparam int CW = 4;

  typedef struct {
    logic [7:0] d;
    bit         l;
    int         gap;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    vv;
  logic [7:0]    dd [2];
  logic          ll [2];
  logic          req0_ready, req1_ready;
  logic          tbr;
  logic          iocs, iorw;
  logic [1:0]    ioaddr;
  logic [7:0]    databus;
  logic          grant_id, locked, err, err_clr;
  logic [CW-1:0] bytes_sent;

  always #5 clk = ~clk;

  spart_tx_arbiter #(.ACK_TIMEOUT(AT), .TX_ADDR(2'b00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(vv[0]), .req0_data(dd[0]), .req0_last(ll[0]), .req0_ready(req0_ready),
    .req1_valid(vv[1]), .req1_data(dd[1]), .req1_last(ll[1]), .req1_ready(req1_ready),
    .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .grant_id(grant_id), .locked(locked), .err(err), .err_clr(err_clr),
    .bytes_sent(bytes_sent)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the arbiter ----------------
  bit         m_strobe, m_ack, m_drain, m_locked, m_owner, m_ptr, m_err, m_last;
  int         m_age, m_cnt;
  logic [7:0] m_data;

  function automatic logic [1:0] exp_ready();
    if (rst || m_strobe || m_ack || m_drain || !tbr) return 2'b00;
    if (m_locked) return m_owner ? {vv[1], 1'b0} : {1'b0, vv[0]};
    if (vv == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return vv;
  endfunction

  always @(posedge clk) begin
    logic [1:0] r;
    bit to;
    r = exp_ready();
    if (rst) begin
      m_strobe = 0; m_ack = 0; m_drain = 0; m_locked = 0; m_owner = 0;
      m_ptr = 0; m_err = 0; m_last = 0; m_age = 0; m_cnt = 0; m_data = 8'h00;
    end else begin
      to = 0;
      if (m_strobe) begin
        m_strobe = 0; m_ack = 1; m_age = 0;
      end else if (m_ack) begin
        if (!tbr) begin
          m_ack = 0; m_drain = 1;
        end else begin
          m_age++;
          if (m_age == AT) begin
            to = 1; m_ack = 0; m_locked = 0; m_ptr = !m_owner;
          end
        end
      end else if (m_drain) begin
        if (tbr) begin
          m_drain = 0;
          m_cnt = (m_cnt + 1) % (1 << CW);
          if (m_last) begin m_locked = 0; m_ptr = !m_owner; end
        end
      end else if (r != 2'b00) begin
        m_owner = r[1];
        m_data = r[1] ? dd[1] : dd[0];
        m_last = r[1] ? ll[1] : ll[0];
        m_locked = 1; m_strobe = 1;
      end
      if (to) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  bit   chk_en = 0;
  bit   acc [2];
  bit   saw_strobe;
  int   cyc = 0;
  int   strobe_cyc = 0;
  int   err_cyc = -1;
  bit   err_prev = 0;
  int   ord[$];
  logic [7:0] sdat[$];

  always @(negedge clk) begin
    logic [1:0] r;
    cyc++;
    r = exp_ready();
    acc[0] = r[0];
    acc[1] = r[1];
    saw_strobe = (iocs === 1'b1) && (iorw === 1'b0);
    if (chk_en) begin
      check("req0_ready", req0_ready, r[0]);
      check("req1_ready", req1_ready, r[1]);
      check("one_ready", req0_ready & req1_ready, 0);
      check("iocs", iocs, m_strobe);
      check("iorw", iorw, !m_strobe);
      check("ioaddr", ioaddr, 2'b00);
      check("databus", databus, m_data);
      check("grant_id", grant_id, m_owner);
      check("locked", locked, m_locked);
      check("err", err, m_err);
      check("bytes_sent", bytes_sent, m_cnt[CW-1:0]);
      check("strobe_while_busy", iocs & ~tbr, 0);
      if (r != 2'b00) ord.push_back(r[1] ? 1 : 0);
      if (saw_strobe) begin sdat.push_back(databus); strobe_cyc = cyc; end
      if (err === 1'b1 && !err_prev && err_cyc < 0) err_cyc = cyc;
      err_prev = (err === 1'b1);
    end
  end

  // ---------------- SPART transmitter + requester feeders ----------------
  item_t qs [2][$];
  bit    deaf = 0;
  bit    rnd = 0;
  int    frame = 4;
  int    busy = 0;

  task automatic feed(input int i);
    item_t it;
    if (vv[i] && acc[i]) void'(qs[i].pop_front());
    if (qs[i].size() > 0) begin
      it = qs[i][0];
      if (it.gap > 0) begin
        vv[i] = 1'b0;
        it.gap--;
        qs[i][0] = it;
      end else begin
        vv[i] = 1'b1; dd[i] = it.d; ll[i] = it.l;
      end
    end else begin
      vv[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (saw_strobe && !deaf) begin
      tbr = 1'b0; busy = frame;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) tbr = 1'b1;
    end
    feed(0);
    feed(1);
    if (rnd) err_clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l, input int gap);
    item_t it;
    it.d = d; it.l = l; it.gap = gap;
    qs[i].push_back(it);
  endtask

  function automatic bit all_idle();
    return !m_strobe && !m_ack && !m_drain && !m_locked && tbr &&
           qs[0].size() == 0 && qs[1].size() == 0 && vv == 2'b00;
  endfunction

  task automatic run_until_idle(input int budget, input string nm);
    int n = 0;
    step();
    while (!all_idle() && n < budget) begin step(); n++; end
    check(nm, n < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tbr = 1'b1; busy = 0; deaf = 0; err_clr = 1'b0;
    qs[0].delete(); qs[1].delete();
    step(); step();
    rst = 1'b0;
    ord.delete(); sdat.delete(); err_cyc = -1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int saved;
    rst = 1'b1; vv = 2'b00; dd[0] = 8'h00; dd[1] = 8'h00; ll[0] = 0; ll[1] = 0;
    tbr = 1'b1; err_clr = 1'b0;
    @(posedge clk);
    chk_en = 1;
    do_reset();
    @(negedge clk); #1;
    check("rst_iocs", iocs, 0);
    check("rst_iorw", iorw, 1);
    check("rst_bytes", bytes_sent, 0);
    check("rst_locked", locked, 0);

    // 1: single byte, long frame
    frame = 160;
    push(0, 8'hA5, 1, 0);
    n = 0;
    while (ord.size() == 0 && n < 20) begin step(); n++; end
    check("t1_accept", ord.size(), 1);
    @(negedge clk); #1;
    check("t1_iocs", iocs, 1);
    check("t1_iorw", iorw, 0);
    check("t1_ioaddr", ioaddr, 0);
    check("t1_databus", databus, 8'hA5);
    check("t1_ready_pulse", req0_ready, 0);
    run_until_idle(400, "t1_idle");
    @(negedge clk); #1;
    check("t1_bytes", bytes_sent, 1);
    check("t1_locked", locked, 0);

    // 2: contention, alternating grants
    frame = 6;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, 8'hA0 + k[7:0], 1, 0);
      push(1, 8'h3C + k[7:0], 1, 0);
    end
    run_until_idle(600, "t2_idle");
    check("t2_count", ord.size(), 6);
    for (int k = 0; k < 6 && k < ord.size(); k++) check("t2_order", ord[k], k % 2);
    if (sdat.size() > 1) check("t2_req1_data", sdat[1], 8'h3C);
    else check("t2_strobes", sdat.size(), 6);

    // 3: packet lock
    do_reset();
    push(0, 8'hB0, 0, 0); push(0, 8'hB1, 0, 0); push(0, 8'hB2, 1, 0);
    push(1, 8'hC0, 1, 0);
    run_until_idle(600, "t3_idle");
    check("t3_count", ord.size(), 4);
    for (int k = 0; k < 4 && k < ord.size(); k++) check("t3_order", ord[k], (k == 3) ? 1 : 0);

    // 4: ack timeout, err_clr, set-wins
    do_reset();
    deaf = 1;
    saved = bytes_sent;
    push(0, 8'hD0, 1, 0);
    run_until_idle(100, "t4_idle");
    @(negedge clk); #1;
    check("t4_err", err, 1);
    check("t4_locked", locked, 0);
    check("t4_bytes", bytes_sent, saved);
    check("t4_latency", err_cyc - strobe_cyc, AT + 1);
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    @(negedge clk); #1;
    check("t4_clr", err, 0);
    push(0, 8'hD1, 1, 0);
    run_until_idle(100, "t4_idle2");
    push(0, 8'hD2, 1, 0);
    n = 0;
    do begin step(); @(negedge clk); #1; n++; end while (!(iocs && !iorw) && n < 20);
    check("t4_strobe2", n < 20, 1);
    for (int k = 0; k < AT; k++) begin step(); err_clr = 1'b1; end
    step(); err_clr = 1'b0;
    @(negedge clk); #1;
    check("t4_set_wins", err, 1);
    run_until_idle(100, "t4_idle3");
    deaf = 0;

    // 5: reset during WAIT_DONE
    frame = 20;
    do_reset();
    push(0, 8'hE0, 0, 0);
    n = 0;
    while (tbr && n < 20) begin step(); n++; end
    check("t5_tbr_low", tbr, 0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_iocs", iocs, 0);
    check("t5_locked", locked, 0);
    check("t5_bytes", bytes_sent, 0);
    check("t5_grant", grant_id, 0);
    check("t5_databus", databus, 0);
    push(0, 8'hE1, 1, 0);
    run_until_idle(200, "t5_idle");
    @(negedge clk); #1;
    check("t5_bytes_after", bytes_sent, 1);

    // 6: owner stall starves the other requester
    frame = 5;
    do_reset();
    push(0, 8'hF0, 0, 0); push(0, 8'hF1, 1, 50);
    push(1, 8'hC1, 1, 0);
    run_until_idle(500, "t6_idle");
    check("t6_count", ord.size(), 3);
    for (int k = 0; k < 3 && k < ord.size(); k++) check("t6_order", ord[k], (k == 2) ? 1 : 0);

    // random traffic, bytes_sent wraps with the narrow counter
    do_reset();
    rnd = 1;
    for (int r = 0; r < 10; r++) begin
      deaf  = ($urandom_range(0, 5) == 0);
      frame = $urandom_range(1, 12);
      for (int i = 0; i < 2; i++) begin
        int np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          int nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++)
            push(i, 8'($urandom), (b == nb - 1), $urandom_range(0, 4));
        end
      end
      run_until_idle(3000, "rnd_idle");
    end
    rnd = 0; err_clr = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spart_tx_arbiter
`default_nettype wire

// File: doc/spart_tx_arbiter.md
Name: spart_tx_arbiter

Overview:
Shares the single SPART transmitter between two byte-stream requesters, for example the driver console path and a debug/trace path.
- Grants the transmitter round-robin and holds the grant for a whole packet, until the requester's last byte.
- Issues the bus write cycle to the transmit buffer (iocs=1, iorw=0, ioaddr=TX address), then tracks tbr until the byte has left the shifter.
- Sits between the requesters and the SPART bus interface, in the same clock domain.

Parameters:
ACK_TIMEOUT, 8, max cycles after the write strobe to wait for tbr to fall before flagging an error (≥2)
TX_ADDR, 2'b00, ioaddr value selecting the transmit buffer
CNT_W, 16, width of the sent-byte counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has a byte
req0_data  in  8  requester 0 byte
req0_last  in  1  byte ends requester 0 packet
req0_ready  out  1  requester 0 byte accepted this cycle (valid&ready)
req1_valid  in  1  requester 1 has a byte
req1_data  in  8  requester 1 byte
req1_last  in  1  byte ends requester 1 packet
req1_ready  out  1  requester 1 byte accepted this cycle
tbr  in  1  transmit buffer ready from SPART (1 = empty)
iocs  out  1  chip select to SPART
iorw  out  1  1 = read, 0 = write
ioaddr  out  2  register address
databus  out  8  write data
grant_id  out  1  current/last granted requester
locked  out  1  packet in progress, grant held
err  out  1  sticky: ack timeout occurred
err_clr  in  1  clears err
bytes_sent  out  CNT_W  bytes completed since reset, wraps

Behaviour:
Decided: one clock, clk; reset rst is synchronous and active-high.

Reset values: state=IDLE; iocs=0, iorw=1, ioaddr=TX_ADDR, databus=0; req*_ready=0; grant_id=0, rr pointer=0; locked=0; err=0; bytes_sent=0. Reset mid-operation abandons the in-flight byte; iocs is 0 from the first cycle after the reset edge.

FSM states:
- IDLE (arbitrate/accept):
  - ready is asserted combinationally only when tbr=1, to one requester:
    - if locked: the locked grant_id only.
    - else: the valid requester; if both are valid, the one selected by the rr pointer.
  - On accept: latch data/last/id, set locked=1, go to STROBE.
  - If locked and the owner has no valid byte, wait with no ready to the other requester. Starvation by a stalled owner is intended.
- STROBE (exactly 1 cycle): iocs=1, iorw=0, ioaddr=TX_ADDR, databus=latched byte. Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK: iocs=0, iorw=1.
  - tbr=0 → WAIT_DONE.
  - Counter reaching ACK_TIMEOUT with tbr still 1 → set err, clear locked, advance the rr pointer, go to IDLE. The byte is not counted.
- WAIT_DONE: on tbr=1:
  - bytes_sent += 1 (wraps at 2^CNT_W).
  - If the latched last=1: clear locked, rr pointer = ~grant_id.
  - Go to IDLE.

Timing:
- Accept at cycle N → strobe at N+1. The SPART drops tbr at N+2, so WAIT_ACK normally lasts 1 cycle.
- Minimum occupancy is one SPART frame. The next accept can occur in the cycle tbr returns high, seen in IDLE.

Other rules:
- databus holds the last written byte outside STROBE.
- At most one ready is high per cycle.
- The write strobe is never issued while tbr=0.
- err_clr and a timeout in the same cycle → err=1 (set wins).

Decomposition:
- spart_pkg: FSM state enum, SPART register address constants (TX=0, STATUS=1, DB_LO=2, DB_HI=3), default ACK_TIMEOUT.
- One sub-module, rr_arb2: two-request round-robin with lock input and pointer update. The rest lives in spart_tx_arbiter.

Test Plan:
1. Single byte: req0 sends 8'hA5 with last=1, tbr=1 → req0_ready for 1 cycle; next cycle iocs=1, iorw=0, ioaddr=0, databus=A5. Model tbr low for 160 cycles → bytes_sent=1, locked=0.
2. Contention: both valid with last=1 after reset → req0 granted first. Once its byte completes, req1 (8'h3C) is granted; pointer alternates over 4 more packets 0,1,0,1.
3. Packet lock: req0 sends 3 bytes (last on the 3rd) while req1 is valid throughout → req1_ready stays 0 until the 3rd byte's tbr returns high; then req1 is granted.
4. Timeout: tbr held 1 after the strobe → err=1 after ACK_TIMEOUT=8 cycles, locked=0, bytes_sent unchanged. err_clr clears it; err_clr concurrent with a new timeout leaves err=1.
5. Reset in WAIT_DONE: assert rst for 1 cycle → all outputs at reset values next cycle, locked=0, bytes_sent=0, a new byte accepted normally.
6. Owner stall: req0 locked, deasserts valid for 50 cycles while req1 is valid → no grant to req1, iocs stays 0; req0 resumes and completes.
